// File: rtl/keypad_pkg.sv
// Shared constants, column state encoding and key-index helpers for the keypad scanner.
// Key index = col*ROWS + row, so key 0 is column 0 / row 0 and key 15 is column 3 / row 3.
package keypad_pkg;

  localparam int KEY_COUNT      = 16;
  localparam int ROWS           = 4;
  localparam int COLS           = 4;
  localparam int GHOST_MAX_KEYS = 2;

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } col_state_e;

  function automatic logic [3:0] key_index(input logic [1:0] col_idx, input logic [1:0] row_idx);
    return 4'(int'(col_idx) * ROWS + int'(row_idx));
  endfunction

  function automatic logic [4:0] popcount16(input logic [KEY_COUNT-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < KEY_COUNT; i++) n = n + 5'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/keypad_emitter.sv
// Queues newly pressed keys and strobes them out lowest index first, one per cycle.
// Registered: a key committed on edge N is strobed after edge N+1; no backpressure, commits OR into the queue.
module keypad_emitter
  import keypad_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 commit_vld,
  input  logic [KEY_COUNT-1:0] commit_mask,
  output logic                 key_valid,
  output logic [3:0]           key_code
);

  logic [KEY_COUNT-1:0] pending_q, pending_d;
  logic                 key_valid_q, key_valid_d;
  logic [3:0]           key_code_q, key_code_d;
  logic [KEY_COUNT-1:0] clr_mask;
  logic [3:0]           sel_code;
  logic                 found;

  always_comb begin
    found    = 1'b0;
    sel_code = '0;
    clr_mask = '0;
    for (int i = 0; i < KEY_COUNT; i++) begin
      if (pending_q[i] && !found) begin
        found       = 1'b1;
        sel_code    = key_index(2'(i / ROWS), 2'(i % ROWS));
        clr_mask[i] = 1'b1;
      end
    end

    key_valid_d = found;
    key_code_d  = found ? sel_code : key_code_q;
    pending_d   = (pending_q & ~clr_mask) | (commit_vld ? commit_mask : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q   <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      pending_q   <= pending_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column walk, frame debounce, new-press strobes; frame = 4*SCAN_CYCLES.
// Optional KEYPAD_GHOST_REJECT_EN drops frames with more than GHOST_MAX_KEYS keys as matrix ghosts.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES    = 20000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ROWS-1:0]      row,
  output logic [COLS-1:0]      col,
  output logic                 key_valid,
  output logic [3:0]           key_code,
  output logic [KEY_COUNT-1:0] keys_down
);

  localparam logic [16:0] DWELL_LAST = 17'(SCAN_CYCLES - 1);
  localparam logic [3:0]  DEB_MAX    = 4'(DEBOUNCE_SCANS);

  logic [ROWS-1:0]      row_meta_q, row_sync_q;
  logic [ROWS-1:0]      rows_act;
  logic [16:0]          timer_q, timer_d;
  col_state_e           state_q, state_d;
  logic [KEY_COUNT-1:0] raw_q, raw_d;
  logic [KEY_COUNT-1:0] prev_frame_q, prev_frame_d;
  logic [3:0]           stable_cnt_q, stable_cnt_d;
  logic [KEY_COUNT-1:0] keys_down_q, keys_down_d;
  logic                 sample, frame_end, ghost;
  logic                 commit_vld;
  logic [KEY_COUNT-1:0] commit_mask;

  assign rows_act = ~row_sync_q;

  always_comb begin
    sample  = (timer_q == DWELL_LAST);
    timer_d = sample ? '0 : timer_q + 17'd1;

    state_d = state_q;
    if (sample) begin
      unique case (state_q)
        COL0:    state_d = COL1;
        COL1:    state_d = COL2;
        COL2:    state_d = COL3;
        default: state_d = COL0;
      endcase
    end

    // raw_d is the completed frame on the COL3 sample edge.
    raw_d = raw_q;
    if (sample) raw_d[{state_q, 2'b00} +: ROWS] = rows_act;
    frame_end = sample && (state_q == COL3);

`ifdef KEYPAD_GHOST_REJECT_EN
    ghost = (popcount16(raw_d) > 5'(GHOST_MAX_KEYS));
`else
    ghost = 1'b0;
`endif

    prev_frame_d = prev_frame_q;
    stable_cnt_d = stable_cnt_q;
    keys_down_d  = keys_down_q;
    commit_vld   = 1'b0;
    commit_mask  = '0;
    if (frame_end) begin
      if (ghost) begin
        stable_cnt_d = '0;
      end else begin
        if (raw_d == prev_frame_q)
          stable_cnt_d = (stable_cnt_q >= DEB_MAX) ? DEB_MAX : stable_cnt_q + 4'd1;
        else
          stable_cnt_d = 4'd1;
        prev_frame_d = raw_d;
        if (stable_cnt_d == DEB_MAX) begin
          commit_vld  = 1'b1;
          commit_mask = raw_d & ~keys_down_q;
          keys_down_d = raw_d;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta_q   <= '1;
      row_sync_q   <= '1;
      timer_q      <= '0;
      state_q      <= COL0;
      raw_q        <= '0;
      prev_frame_q <= '0;
      stable_cnt_q <= '0;
      keys_down_q  <= '0;
    end else begin
      row_meta_q   <= row;
      row_sync_q   <= row_meta_q;
      timer_q      <= timer_d;
      state_q      <= state_d;
      raw_q        <= raw_d;
      prev_frame_q <= prev_frame_d;
      stable_cnt_q <= stable_cnt_d;
      keys_down_q  <= keys_down_d;
    end
  end

  assign col       = ~(4'b0001 << state_q);
  assign keys_down = keys_down_q;

  keypad_emitter u_emitter (
    .clk         (clk),
    .reset       (reset),
    .commit_vld  (commit_vld),
    .commit_mask (commit_mask),
    .key_valid   (key_valid),
    .key_code    (key_code)
  );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_CYCLES=10, DEBOUNCE_SCANS=4 and a matrix model on row.
// Edge numbering: E0 is the reset edge, a frame ends on every edge that is a multiple of 40.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] keys_down;
  logic [15:0] pressed = 16'h0000;

  int vectors = 0;
  int errors = 0;
  int cur_e = 0;
  int strobe_cnt = 0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_CYCLES(10), .DEBOUNCE_SCANS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .keys_down (keys_down)
  );

  // A pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!col[c])
        for (int r = 0; r < 4; r++)
          if (pressed[c*4+r]) row[r] = 1'b0;
  end

  always @(posedge clk) begin
    #2;
    if (key_valid === 1'b1) strobe_cnt++;
  end

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    cur_e = 0;
  endtask

  task automatic adv_to(input int e);
    repeat (e - cur_e) @(posedge clk);
    @(negedge clk);
    cur_e = e;
  endtask

  task automatic test_reset();
    pressed = 16'h0000;
    do_reset();
    strobe_cnt = 0;
    vectors++; if (col !== 4'b1110) begin errors++; $display("FAIL reset_col got=%b want=1110", col); end
    vectors++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", key_valid); end
    vectors++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code got=%0d want=0", key_code); end
    vectors++; if (keys_down !== 16'h0000) begin errors++; $display("FAIL reset_keys got=%h want=0000", keys_down); end
    adv_to(9);
    vectors++; if (col !== 4'b1110) begin errors++; $display("FAIL walk_e9 got=%b want=1110", col); end
    adv_to(10);
    vectors++; if (col !== 4'b1101) begin errors++; $display("FAIL walk_e10 got=%b want=1101", col); end
    adv_to(20);
    vectors++; if (col !== 4'b1011) begin errors++; $display("FAIL walk_e20 got=%b want=1011", col); end
    adv_to(30);
    vectors++; if (col !== 4'b0111) begin errors++; $display("FAIL walk_e30 got=%b want=0111", col); end
    adv_to(40);
    vectors++; if (col !== 4'b1110) begin errors++; $display("FAIL walk_e40 got=%b want=1110", col); end
    adv_to(200);
    vectors++; if (keys_down !== 16'h0000) begin errors++; $display("FAIL idle_keys got=%h want=0000", keys_down); end
    vectors++; if (strobe_cnt !== 0) begin errors++; $display("FAIL idle_strobes got=%0d want=0", strobe_cnt); end
  endtask

  task automatic test_single_key();
    pressed = 16'h0040;
    do_reset();
    strobe_cnt = 0;
    adv_to(159);
    vectors++; if (keys_down !== 16'h0000) begin errors++; $display("FAIL k6_early got=%h want=0000", keys_down); end
    adv_to(160);
    vectors++; if (keys_down !== 16'h0040) begin errors++; $display("FAIL k6_commit got=%h want=0040", keys_down); end
    vectors++; if (key_valid !== 1'b0) begin errors++; $display("FAIL k6_valid_e160 got=%b want=0", key_valid); end
    adv_to(161);
    vectors++; if (key_valid !== 1'b1) begin errors++; $display("FAIL k6_valid_e161 got=%b want=1", key_valid); end
    vectors++; if (key_code !== 4'd6) begin errors++; $display("FAIL k6_code got=%0d want=6", key_code); end
    adv_to(162);
    vectors++; if (key_valid !== 1'b0) begin errors++; $display("FAIL k6_valid_e162 got=%b want=0", key_valid); end
    vectors++; if (strobe_cnt !== 1) begin errors++; $display("FAIL k6_strobes got=%0d want=1", strobe_cnt); end
  endtask

  task automatic test_bounce();
    pressed = 16'h0000;
    do_reset();
    strobe_cnt = 0;
    pressed = 16'h0008;
    adv_to(80);
    pressed = 16'h0000;
    adv_to(320);
    vectors++; if (keys_down !== 16'h0000) begin errors++; $display("FAIL bounce_keys got=%h want=0000", keys_down); end
    vectors++; if (strobe_cnt !== 0) begin errors++; $display("FAIL bounce_strobes got=%0d want=0", strobe_cnt); end
  endtask

  task automatic test_two_keys();
    pressed = 16'h0000;
    do_reset();
    strobe_cnt = 0;
    pressed = 16'h4002;
    adv_to(160);
    vectors++; if (keys_down !== 16'h4002) begin errors++; $display("FAIL two_commit got=%h want=4002", keys_down); end
    vectors++; if (key_valid !== 1'b0) begin errors++; $display("FAIL two_valid_e160 got=%b want=0", key_valid); end
    adv_to(161);
    vectors++; if (key_valid !== 1'b1 || key_code !== 4'd1) begin errors++; $display("FAIL two_first got=%b/%0d want=1/1", key_valid, key_code); end
    adv_to(162);
    vectors++; if (key_valid !== 1'b1 || key_code !== 4'd14) begin errors++; $display("FAIL two_second got=%b/%0d want=1/14", key_valid, key_code); end
    adv_to(163);
    vectors++; if (key_valid !== 1'b0 || key_code !== 4'd14) begin errors++; $display("FAIL two_hold got=%b/%0d want=0/14", key_valid, key_code); end
    vectors++; if (strobe_cnt !== 2) begin errors++; $display("FAIL two_strobes got=%0d want=2", strobe_cnt); end
  endtask

  task automatic test_reset_pending();
    pressed = 16'h0040;
    do_reset();
    adv_to(100);
    do_reset();
    strobe_cnt = 0;
    vectors++; if (col !== 4'b1110 || keys_down !== 16'h0000) begin errors++; $display("FAIL mid_reset got=%b/%h want=1110/0000", col, keys_down); end
    adv_to(159);
    vectors++; if (keys_down !== 16'h0000) begin errors++; $display("FAIL mid_reset_early got=%h want=0000", keys_down); end
    adv_to(160);
    vectors++; if (keys_down !== 16'h0040) begin errors++; $display("FAIL mid_reset_commit got=%h want=0040", keys_down); end
    do_reset();
    vectors++; if (key_valid !== 1'b0) begin errors++; $display("FAIL pend_reset_valid got=%b want=0", key_valid); end
    vectors++; if (keys_down !== 16'h0000 || key_code !== 4'd0) begin errors++; $display("FAIL pend_reset_state got=%h/%0d want=0000/0", keys_down, key_code); end
    vectors++; if (strobe_cnt !== 0) begin errors++; $display("FAIL pend_reset_strobes got=%0d want=0", strobe_cnt); end
    adv_to(160);
    vectors++; if (keys_down !== 16'h0040) begin errors++; $display("FAIL rearm_commit got=%h want=0040", keys_down); end
    adv_to(161);
    vectors++; if (key_valid !== 1'b1 || key_code !== 4'd6) begin errors++; $display("FAIL rearm_strobe got=%b/%0d want=1/6", key_valid, key_code); end
  endtask

  task automatic test_ghost();
    pressed = 16'h0000;
    do_reset();
    strobe_cnt = 0;
    pressed = 16'h0421;
`ifdef KEYPAD_GHOST_REJECT_EN
    adv_to(400);
    vectors++; if (keys_down !== 16'h0000) begin errors++; $display("FAIL ghost_keys got=%h want=0000", keys_down); end
    vectors++; if (strobe_cnt !== 0) begin errors++; $display("FAIL ghost_strobes got=%0d want=0", strobe_cnt); end
`else
    adv_to(160);
    vectors++; if (keys_down !== 16'h0421) begin errors++; $display("FAIL three_commit got=%h want=0421", keys_down); end
    adv_to(161);
    vectors++; if (key_valid !== 1'b1 || key_code !== 4'd0) begin errors++; $display("FAIL three_k0 got=%b/%0d want=1/0", key_valid, key_code); end
    adv_to(162);
    vectors++; if (key_valid !== 1'b1 || key_code !== 4'd5) begin errors++; $display("FAIL three_k5 got=%b/%0d want=1/5", key_valid, key_code); end
    adv_to(163);
    vectors++; if (key_valid !== 1'b1 || key_code !== 4'd10) begin errors++; $display("FAIL three_k10 got=%b/%0d want=1/10", key_valid, key_code); end
    adv_to(164);
    vectors++; if (key_valid !== 1'b0) begin errors++; $display("FAIL three_end got=%b want=0", key_valid); end
    vectors++; if (strobe_cnt !== 3) begin errors++; $display("FAIL three_strobes got=%0d want=3", strobe_cnt); end
`endif
  endtask

  task automatic test_repress();
    pressed = 16'h0040;
    do_reset();
    strobe_cnt = 0;
    adv_to(162);
    pressed = 16'h0000;
    adv_to(319);
    vectors++; if (keys_down !== 16'h0040) begin errors++; $display("FAIL release_early got=%h want=0040", keys_down); end
    adv_to(320);
    vectors++; if (keys_down !== 16'h0000) begin errors++; $display("FAIL release_commit got=%h want=0000", keys_down); end
    vectors++; if (strobe_cnt !== 1) begin errors++; $display("FAIL release_strobes got=%0d want=1", strobe_cnt); end
    pressed = 16'h0040;
    adv_to(480);
    vectors++; if (keys_down !== 16'h0040) begin errors++; $display("FAIL repress_commit got=%h want=0040", keys_down); end
    adv_to(481);
    vectors++; if (key_valid !== 1'b1 || key_code !== 4'd6) begin errors++; $display("FAIL repress_strobe got=%b/%0d want=1/6", key_valid, key_code); end
    vectors++; if (strobe_cnt !== 2) begin errors++; $display("FAIL repress_strobes got=%0d want=2", strobe_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_bounce();
    test_two_keys();
    test_reset_pending();
    test_ghost();
    test_repress();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
